ddr3_wr_burst_ctrl: RTL and testbench
=====================================

Name: ddr3_wr_burst_ctrl

Overview:
- Write-side DDR3 master between the capture write FIFO (128-bit FWFT read port) and the MIG native user interface, all in MIG ui_clk.
- Issues BURST_LEN-beat write bursts into one of two ping-pong frame buffers, driven by FIFO fill level.
- On a frame-clear pulse, swaps buffers and publishes the base of the just-completed frame for the read-side.

Parameters:
- ADDR_W, 28, MIG app_addr width
- DATA_W, 128, app_wdf_data width (16-bit DDR3, BL8)
- CNT_W, 10, FIFO read-count width
- BURST_LEN, 16, beats per burst
- ADDR_STEP, 8, app_addr increment per beat
- FRAME0_BASE, 28'h0000000, buffer 0 base
- FRAME1_BASE, 28'h0100000, buffer 1 base
- FRAME_BEATS, 45120, max beats per frame (752x480x2 B / 16 B)

Ports:
- i_clk  in  1  MIG ui_clk
- i_rst_n  in  1  async active-low reset
- i_calib_done  in  1  MIG init_calib_complete
- i_frame_clr  in  1  one-cycle pulse, i_clk domain: new frame starts
- i_fifo_dout  in  DATA_W  FWFT FIFO head word
- i_fifo_empty  in  1  FIFO empty
- i_fifo_rd_count  in  CNT_W  FIFO words available
- o_fifo_rden  out  1  pop head word
- o_app_addr  out  ADDR_W  command address
- o_app_cmd  out  3  always 3'b000 (write)
- o_app_en  out  1  command valid
- i_app_rdy  in  1  command accepted
- o_app_wdf_data  out  DATA_W  write data
- o_app_wdf_wren  out  1  data valid
- o_app_wdf_end  out  1  = o_app_wdf_wren (BL8, one beat per cmd)
- o_app_wdf_mask  out  DATA_W/8  always 0
- i_app_wdf_rdy  in  1  data accepted
- o_wr_frame_idx  out  1  buffer being written
- o_rd_frame_base  out  ADDR_W  base of last completed frame
- o_frame_done  out  1  one-cycle pulse on swap
- o_overflow  out  1  sticky: frame exceeded FRAME_BEATS
- o_busy  out  1  high in S_BURST/S_DRAIN

Behaviour:
- Reset values: all outputs 0, except o_rd_frame_base=FRAME1_BASE; internals: beat_cnt=0, burst_cnt=0, clr_pend=0, wr_addr=FRAME0_BASE.
- States: S_IDLE, S_ARM, S_BURST, S_DRAIN.
- S_IDLE: wait i_calib_done=1, then -> S_ARM. Pulses of i_frame_clr arriving in S_IDLE are ignored.
- clr_pend: set by i_frame_clr in any non-IDLE state; cleared only when the swap is taken in S_ARM.
- S_ARM, priority order:
  - (1) clr_pend -> swap for one cycle, stay in S_ARM:
    - o_wr_frame_idx toggles.
    - wr_addr loads the new buffer base.
    - o_rd_frame_base takes the old buffer base.
    - o_frame_done pulses.
    - beat_cnt=0, o_overflow=0.
  - (2) o_overflow=1 and !i_fifo_empty -> S_DRAIN.
  - (3) i_fifo_rd_count >= BURST_LEN -> S_BURST with burst_cnt=0.
  - Otherwise stay in S_ARM.
- S_BURST, per beat:
  - o_app_en and o_app_wdf_wren are asserted together with o_app_addr=wr_addr and o_app_wdf_data=i_fifo_dout.
  - cmd_ok is set when o_app_en & i_app_rdy; o_app_en then drops. data_ok is set when o_app_wdf_wren & i_app_wdf_rdy; o_app_wdf_wren then drops. The two may complete in different cycles.
  - Beat completes in the cycle both are satisfied (current-cycle handshakes included):
    - o_fifo_rden pulses 1 cycle.
    - wr_addr += ADDR_STEP; beat_cnt++; burst_cnt++.
    - Flags clear.
    - Next beat is driven in the following cycle, so at best 1 beat per 2 cycles.
  - burst_cnt==BURST_LEN-1 completing -> S_ARM.
  - beat_cnt reaching FRAME_BEATS -> o_overflow=1, -> S_ARM; the remaining burst beats are not issued.
- S_DRAIN:
  - o_fifo_rden=1 each cycle while !i_fifo_empty.
  - No MIG commands are issued.
  - -> S_ARM when empty or clr_pend.
- Address arithmetic: ADDR_W wide, unsigned, no wrap; FRAME_BEATS bounds the span to FRAME_BEATS*ADDR_STEP.
- i_frame_clr mid-burst: the burst finishes, then the swap happens in S_ARM. A second pulse while pending is merged.
- i_calib_done falling: treated as reset of the FSM to S_IDLE next cycle; o_app_en/o_app_wdf_wren drop immediately (combinationally gated).

Decomposition:
- Package ddr3_cache_pkg: MIG command codes (CMD_WRITE=3'b000, CMD_READ=3'b001), FRAME0_BASE/FRAME1_BASE, FRAME_BEATS, state encoding.
- Sub-module ddr3_beat_hs: two-flag cmd/data handshake tracker emitting beat_done. The rest stays flat.

Test Plan:
- Reset/calib: i_rst_n low then high, i_calib_done=0 with 32 words queued -> no o_app_en, no o_fifo_rden; set i_calib_done=1 -> first command at addr 0.
- Basic burst: preload 16 words, ready signals tied high -> 16 beats at addresses 0,8,...,120, 16 rden pulses; no burst issued with 15 words.
- Skewed ready: i_app_rdy high only on odd cycles, i_app_wdf_rdy only on even cycles -> each beat pops exactly once, data/address pairing intact, 16 beats total.
- Frame clear mid-burst: pulse i_frame_clr at beat 5 -> burst completes to beat 15; then o_frame_done=1 for 1 cycle, o_rd_frame_base=0, o_wr_frame_idx=1, next address 28'h0100000.
- Overflow: FRAME_BEATS=32 override, feed 48 words -> 32 beats written, o_overflow=1, last 16 words drained with no commands; i_frame_clr -> o_overflow=0.
- Calib loss: drop i_calib_done mid-burst -> o_app_en=0 that cycle, FSM in S_IDLE, no further rden.

Source files
------------

// File: rtl/ddr3_cache_pkg.sv
// Shared constants and types for the DDR3 frame-cache write path:
// MIG command codes, default ping-pong buffer layout and FSM encoding.
package ddr3_cache_pkg;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    localparam logic [27:0] DEF_FRAME0_BASE = 28'h0000000;
    localparam logic [27:0] DEF_FRAME1_BASE = 28'h0100000;
    // 752 x 480 pixels x 2 bytes / 16 bytes per beat
    localparam int          DEF_FRAME_BEATS = 45120;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_BURST = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

endpackage

// File: rtl/ddr3_beat_hs.sv
// Two-flag handshake tracker for one MIG write beat. The command and data
// channels are offered together and may be accepted in different cycles;
// each channel stops asserting its valid once accepted, and beat_done fires
// in the cycle the second (or both) acceptances land.
module ddr3_beat_hs (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic app_rdy,
    input  logic wdf_rdy,
    output logic app_en,
    output logic wdf_wren,
    output logic beat_done
);

    logic cmd_ok;
    logic data_ok;
    logic cmd_hit;
    logic data_hit;

    assign app_en    = active && !cmd_ok;
    assign wdf_wren  = active && !data_ok;
    assign cmd_hit   = app_en && app_rdy;
    assign data_hit  = wdf_wren && wdf_rdy;
    assign beat_done = active && (cmd_ok || cmd_hit) && (data_ok || data_hit);

    // Remember which channel has already been accepted for the current beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ok  <= 1'b0;
            data_ok <= 1'b0;
        end else if (!active || beat_done) begin
            // NOTE: non-blocking assignments keep every flop updating from
            // the same pre-edge values, so the flags never see each other's
            // new value within a cycle.
            cmd_ok  <= 1'b0;
            data_ok <= 1'b0;
        end else begin
            if (cmd_hit) begin
                cmd_ok <= 1'b1;
            end
            if (data_hit) begin
                data_ok <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ddr3_wr_burst_ctrl.sv
// Write-side DDR3 master: moves 128-bit words from the capture FIFO (FWFT)
// into one of two ping-pong frame buffers through the MIG native interface,
// in BURST_LEN-beat bursts gated by FIFO fill level. A frame-clear pulse
// swaps buffers and publishes the base of the frame just completed.
module ddr3_wr_burst_ctrl
    import ddr3_cache_pkg::*;
#(
    parameter int                ADDR_W      = 28,
    parameter int                DATA_W      = 128,
    parameter int                CNT_W       = 10,
    parameter int                BURST_LEN   = 16,
    parameter int                ADDR_STEP   = 8,
    parameter logic [ADDR_W-1:0] FRAME0_BASE = DEF_FRAME0_BASE,
    parameter logic [ADDR_W-1:0] FRAME1_BASE = DEF_FRAME1_BASE,
    parameter int                FRAME_BEATS = DEF_FRAME_BEATS
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_calib_done,
    input  logic                i_frame_clr,
    input  logic [DATA_W-1:0]   i_fifo_dout,
    input  logic                i_fifo_empty,
    input  logic [CNT_W-1:0]    i_fifo_rd_count,
    output logic                o_fifo_rden,
    output logic [ADDR_W-1:0]   o_app_addr,
    output logic [2:0]          o_app_cmd,
    output logic                o_app_en,
    input  logic                i_app_rdy,
    output logic [DATA_W-1:0]   o_app_wdf_data,
    output logic                o_app_wdf_wren,
    output logic                o_app_wdf_end,
    output logic [DATA_W/8-1:0] o_app_wdf_mask,
    input  logic                i_app_wdf_rdy,
    output logic                o_wr_frame_idx,
    output logic [ADDR_W-1:0]   o_rd_frame_base,
    output logic                o_frame_done,
    output logic                o_overflow,
    output logic                o_busy
);

    localparam int BEAT_W = $clog2(FRAME_BEATS + 1);
    localparam int BCNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    state_e            state;
    logic [ADDR_W-1:0] wr_addr;
    logic [BEAT_W-1:0] beat_cnt;
    logic [BCNT_W-1:0] burst_cnt;
    logic              clr_pend;
    logic              beat_gap;
    logic              wr_frame_idx;
    logic [ADDR_W-1:0] rd_frame_base;
    logic              frame_done;
    logic              overflow;

    logic              beat_active;
    logic              beat_done;
    logic              app_en;
    logic              wdf_wren;

    // A beat is offered in S_BURST except in the cycle right after a beat
    // completes, which lets the FWFT head advance to the next word. Losing
    // calibration withdraws the offer in the same cycle.
    assign beat_active = i_calib_done && (state == S_BURST) && !beat_gap;

    ddr3_beat_hs u_beat_hs (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .active    (beat_active),
        .app_rdy   (i_app_rdy),
        .wdf_rdy   (i_app_wdf_rdy),
        .app_en    (app_en),
        .wdf_wren  (wdf_wren),
        .beat_done (beat_done)
    );

    // Main controller: calibration gating, buffer swap, burst sequencing and
    // overflow drain.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= S_IDLE;
            wr_addr       <= FRAME0_BASE;
            beat_cnt      <= '0;
            burst_cnt     <= '0;
            clr_pend      <= 1'b0;
            beat_gap      <= 1'b0;
            wr_frame_idx  <= 1'b0;
            rd_frame_base <= FRAME1_BASE;
            frame_done    <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            beat_gap   <= 1'b0;

            // Frame clears seen before calibration are meaningless; later
            // ones wait (and merge) until the controller is between bursts.
            if (i_frame_clr && (state != S_IDLE)) begin
                clr_pend <= 1'b1;
            end

            if (!i_calib_done) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        state <= S_ARM;
                    end

                    S_ARM: begin
                        if (clr_pend) begin
                            clr_pend      <= 1'b0;
                            wr_frame_idx  <= !wr_frame_idx;
                            wr_addr       <= wr_frame_idx ? FRAME0_BASE : FRAME1_BASE;
                            rd_frame_base <= wr_frame_idx ? FRAME1_BASE : FRAME0_BASE;
                            frame_done    <= 1'b1;
                            beat_cnt      <= '0;
                            overflow      <= 1'b0;
                        end else if (overflow && !i_fifo_empty) begin
                            state <= S_DRAIN;
                        end else if (!overflow &&
                                     (i_fifo_rd_count >= CNT_W'(BURST_LEN))) begin
                            // an overflowed frame never issues further writes
                            burst_cnt <= '0;
                            state     <= S_BURST;
                        end
                    end

                    S_BURST: begin
                        if (beat_done) begin
                            wr_addr   <= wr_addr + ADDR_W'(ADDR_STEP);
                            beat_cnt  <= beat_cnt + BEAT_W'(1);
                            burst_cnt <= burst_cnt + BCNT_W'(1);
                            beat_gap  <= 1'b1;
                            if (beat_cnt == BEAT_W'(FRAME_BEATS - 1)) begin
                                overflow <= 1'b1;
                                state    <= S_ARM;
                            end else if (burst_cnt == BCNT_W'(BURST_LEN - 1)) begin
                                state <= S_ARM;
                            end
                        end
                    end

                    S_DRAIN: begin
                        if (i_fifo_empty || clr_pend) begin
                            state <= S_ARM;
                        end
                    end

                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_fifo_rden     = beat_done ||
                             ((state == S_DRAIN) && i_calib_done && !i_fifo_empty);
    assign o_app_addr      = wr_addr;
    assign o_app_cmd       = CMD_WRITE;
    assign o_app_en        = app_en;
    assign o_app_wdf_data  = wdf_wren ? i_fifo_dout : '0;
    assign o_app_wdf_wren  = wdf_wren;
    assign o_app_wdf_end   = wdf_wren;
    assign o_app_wdf_mask  = '0;
    assign o_wr_frame_idx  = wr_frame_idx;
    assign o_rd_frame_base = rd_frame_base;
    assign o_frame_done    = frame_done;
    assign o_overflow      = overflow;
    assign o_busy          = (state == S_BURST) || (state == S_DRAIN);

endmodule

// File: tb/tb_ddr3_wr_burst_ctrl.sv
// Bench for ddr3_wr_burst_ctrl: a queue-based FWFT FIFO model feeds the DUT,
// a monitor logs accepted commands/data and pops, and directed vectors plus
// hand-written sequences compare against hand-computed expectations.
module tb_ddr3_wr_burst_ctrl;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;
    localparam int CNT_W  = 10;
    localparam logic [ADDR_W-1:0] F1_BASE = 28'h0100000;

    logic                i_clk = 1'b0;
    logic                i_rst_n = 1'b0;
    logic                i_calib_done = 1'b0;
    logic                i_frame_clr = 1'b0;
    logic [DATA_W-1:0]   i_fifo_dout = '0;
    logic                i_fifo_empty = 1'b1;
    logic [CNT_W-1:0]    i_fifo_rd_count = '0;
    logic                o_fifo_rden;
    logic [ADDR_W-1:0]   o_app_addr;
    logic [2:0]          o_app_cmd;
    logic                o_app_en;
    logic                i_app_rdy = 1'b1;
    logic [DATA_W-1:0]   o_app_wdf_data;
    logic                o_app_wdf_wren;
    logic                o_app_wdf_end;
    logic [DATA_W/8-1:0] o_app_wdf_mask;
    logic                i_app_wdf_rdy = 1'b1;
    logic                o_wr_frame_idx;
    logic [ADDR_W-1:0]   o_rd_frame_base;
    logic                o_frame_done;
    logic                o_overflow;
    logic                o_busy;

    ddr3_wr_burst_ctrl #(.FRAME_BEATS(32)) dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_calib_done    (i_calib_done),
        .i_frame_clr     (i_frame_clr),
        .i_fifo_dout     (i_fifo_dout),
        .i_fifo_empty    (i_fifo_empty),
        .i_fifo_rd_count (i_fifo_rd_count),
        .o_fifo_rden     (o_fifo_rden),
        .o_app_addr      (o_app_addr),
        .o_app_cmd       (o_app_cmd),
        .o_app_en        (o_app_en),
        .i_app_rdy       (i_app_rdy),
        .o_app_wdf_data  (o_app_wdf_data),
        .o_app_wdf_wren  (o_app_wdf_wren),
        .o_app_wdf_end   (o_app_wdf_end),
        .o_app_wdf_mask  (o_app_wdf_mask),
        .i_app_wdf_rdy   (i_app_wdf_rdy),
        .o_wr_frame_idx  (o_wr_frame_idx),
        .o_rd_frame_base (o_rd_frame_base),
        .o_frame_done    (o_frame_done),
        .o_overflow      (o_overflow),
        .o_busy          (o_busy)
    );

    always #5 i_clk = ~i_clk;

    // ---------------- bench state ----------------
    logic [DATA_W-1:0] fifo_q[$];
    logic [ADDR_W-1:0] addr_log[$];
    logic [DATA_W-1:0] data_log[$];
    int  rden_cnt;
    int  en_cycles;
    int  done_cnt;
    int  rdy_mode;
    int  cyc;
    logic pop_pending;
    int  n_checks;
    int  n_pass;

    typedef struct {
        int          words;
        int          mode;
        int          exp_beats;
        int          exp_rden;
        logic        exp_ovf;
        logic [27:0] exp_last;
    } vec_t;

    vec_t vecs[7];

    function automatic logic [DATA_W-1:0] mk_word(input int tag, input int k);
        mk_word = {8'(tag), 24'(k), 32'hDEAD_BEEF ^ 32'(k), 32'(k * 7 + 1), 32'(k)};
    endfunction

    function automatic void refresh_fifo();
        i_fifo_empty    = (fifo_q.size() == 0);
        i_fifo_rd_count = CNT_W'(fifo_q.size());
        i_fifo_dout     = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    endfunction

    // FIFO and ready-pattern driver: applies the pop the DUT requested in the
    // previous cycle, then sets this cycle's inputs just after the edge.
    always @(posedge i_clk) begin
        #1;
        if (pop_pending && (fifo_q.size() > 0)) begin
            void'(fifo_q.pop_front());
        end
        pop_pending = 1'b0;
        cyc++;
        case (rdy_mode)
            1: begin
                i_app_rdy     = cyc[0];
                i_app_wdf_rdy = ~cyc[0];
            end
            2: begin
                i_app_rdy     = ((cyc % 3) == 0);
                i_app_wdf_rdy = 1'b1;
            end
            default: begin
                i_app_rdy     = 1'b1;
                i_app_wdf_rdy = 1'b1;
            end
        endcase
        refresh_fifo();
    end

    // Monitor: sampled mid-cycle while inputs and outputs are stable.
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_app_en && i_app_rdy)           addr_log.push_back(o_app_addr);
            if (o_app_wdf_wren && i_app_wdf_rdy) data_log.push_back(o_app_wdf_data);
            if (o_app_en)                        en_cycles++;
            if (o_frame_done)                    done_cnt++;
            if (o_fifo_rden) begin
                rden_cnt++;
                pop_pending = 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge i_clk);
        #1;
    endtask

    task automatic to_drive();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset(input int mode);
        i_rst_n      = 1'b0;
        i_calib_done = 1'b0;
        i_frame_clr  = 1'b0;
        rdy_mode     = mode;
        fifo_q.delete();
        addr_log.delete();
        data_log.delete();
        rden_cnt    = 0;
        en_cycles   = 0;
        done_cnt    = 0;
        pop_pending = 1'b0;
        refresh_fifo();
        repeat (3) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
    endtask

    task automatic push_words(input int tag, input int n);
        for (int k = 0; k < n; k++) fifo_q.push_back(mk_word(tag, k));
        refresh_fifo();
    endtask

    task automatic pulse_clr();
        to_drive();
        i_frame_clr = 1'b1;
        to_drive();
        i_frame_clr = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int max_cyc, input string name);
        int   i;
        logic ok;
        i = 0;
        while ((addr_log.size() < n) && (i < max_cyc)) begin
            run(1);
            i++;
        end
        ok = (addr_log.size() >= n);
        check(name, ok, 1'b1);
    endtask

    // Beats logged from index 'first' must hit base + 8k with word k of 'tag'.
    function automatic int pair_errs(input int tag, input logic [27:0] base,
                                     input int first, input int n);
        int errs;
        errs = 0;
        for (int k = 0; k < n; k++) begin
            if ((first + k >= addr_log.size()) || (first + k >= data_log.size())) begin
                errs++;
            end else begin
                if (addr_log[first + k] !== base + 28'(8 * k)) errs++;
                if (data_log[first + k] !== mk_word(tag, k))   errs++;
            end
        end
        return errs;
    endfunction

    initial begin
        int   snap_rden;
        int   snap_beats;
        int   i;
        logic ok;

        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;
        rdy_mode = 0;

        // words, ready mode, beats, pops, overflow, last address
        vecs[0] = '{16, 0, 16, 16, 1'b0, 28'd120};
        vecs[1] = '{15, 0,  0,  0, 1'b0, 28'd0};
        vecs[2] = '{16, 1, 16, 16, 1'b0, 28'd120};
        vecs[3] = '{20, 0, 16, 16, 1'b0, 28'd120};
        vecs[4] = '{32, 2, 32, 32, 1'b1, 28'd248};
        vecs[5] = '{48, 0, 32, 48, 1'b1, 28'd248};
        vecs[6] = '{31, 1, 16, 16, 1'b0, 28'd120};

        // ---- reset values and calibration gating ----
        do_reset(0);
        run(1);
        check("rst_rd_base",  o_rd_frame_base, F1_BASE);
        check("rst_frame_idx", o_wr_frame_idx, 1'b0);
        check("rst_overflow", o_overflow, 1'b0);
        check("rst_done",     o_frame_done, 1'b0);
        check("rst_busy",     o_busy, 1'b0);
        check("rst_app_en",   o_app_en, 1'b0);
        check("rst_rden",     o_fifo_rden, 1'b0);
        to_drive();
        push_words(1, 32);
        run(40);
        check("nocal_app_en", en_cycles, 0);
        check("nocal_rden",   rden_cnt, 0);
        to_drive();
        i_calib_done = 1'b1;
        i  = 0;
        ok = 1'b0;
        while (!ok && (i < 20)) begin
            run(1);
            ok = o_app_en;
            i++;
        end
        check("cal_first_cmd",  ok, 1'b1);
        check("cal_first_addr", o_app_addr, 28'd0);
        check("cal_first_data", o_app_wdf_data, mk_word(1, 0));
        check("cal_cmd_code",   o_app_cmd, 3'b000);

        // ---- table-driven bursts ----
        for (int v = 0; v < 7; v++) begin
            do_reset(vecs[v].mode);
            to_drive();
            i_calib_done = 1'b1;
            push_words(10 + v, vecs[v].words);
            run(300);
            check($sformatf("row%0d_beats", v),  addr_log.size(), vecs[v].exp_beats);
            check($sformatf("row%0d_data", v),   data_log.size(), vecs[v].exp_beats);
            check($sformatf("row%0d_rden", v),   rden_cnt, vecs[v].exp_rden);
            check($sformatf("row%0d_ovf", v),    o_overflow, vecs[v].exp_ovf);
            check($sformatf("row%0d_left", v),   fifo_q.size(), vecs[v].words - vecs[v].exp_rden);
            check($sformatf("row%0d_pair", v),   pair_errs(10 + v, 28'd0, 0, vecs[v].exp_beats), 0);
            check($sformatf("row%0d_busy", v),   o_busy, 1'b0);
            if (addr_log.size() > 0) begin
                check($sformatf("row%0d_last", v), addr_log[addr_log.size() - 1], vecs[v].exp_last);
            end
        end

        // ---- frame clear mid-burst, second pulse merged ----
        do_reset(0);
        to_drive();
        i_calib_done = 1'b1;
        push_words(2, 16);
        wait_beats(5, 100, "clr_wait5");
        pulse_clr();
        wait_beats(8, 100, "clr_wait8");
        check("clr_no_early_done", done_cnt, 0);
        pulse_clr();
        run(60);
        check("clr_beats",     addr_log.size(), 16);
        check("clr_pair",      pair_errs(2, 28'd0, 0, 16), 0);
        check("clr_done_cnt",  done_cnt, 1);
        check("clr_rd_base",   o_rd_frame_base, 28'd0);
        check("clr_frame_idx", o_wr_frame_idx, 1'b1);
        to_drive();
        push_words(3, 16);
        run(60);
        check("clr_beats2", addr_log.size(), 32);
        if (addr_log.size() > 16) begin
            check("clr_next_addr", addr_log[16], F1_BASE);
        end
        check("clr_pair2", pair_errs(3, F1_BASE, 16, 16), 0);

        // ---- overflow, drain, then clear ----
        do_reset(0);
        to_drive();
        i_calib_done = 1'b1;
        push_words(4, 48);
        run(250);
        check("ovf_beats", addr_log.size(), 32);
        check("ovf_rden",  rden_cnt, 48);
        check("ovf_flag",  o_overflow, 1'b1);
        pulse_clr();
        run(5);
        check("ovf_cleared", o_overflow, 1'b0);
        check("ovf_done",    done_cnt, 1);
        check("ovf_idx",     o_wr_frame_idx, 1'b1);
        check("ovf_rd_base", o_rd_frame_base, 28'd0);

        // ---- calibration loss mid-burst ----
        do_reset(0);
        to_drive();
        i_calib_done = 1'b1;
        push_words(5, 16);
        i  = 0;
        ok = 1'b0;
        while (!ok && (i < 100)) begin
            run(1);
            ok = o_app_en && (addr_log.size() >= 3);
            i++;
        end
        check("cal_loss_sync", ok, 1'b1);
        to_drive();
        to_drive();
        i_calib_done = 1'b0;
        run(1);
        check("cal_loss_en",   o_app_en, 1'b0);
        check("cal_loss_wren", o_app_wdf_wren, 1'b0);
        check("cal_loss_rden", o_fifo_rden, 1'b0);
        snap_rden  = rden_cnt;
        snap_beats = addr_log.size();
        run(1);
        check("cal_loss_idle", o_busy, 1'b0);
        run(20);
        check("cal_loss_norden", rden_cnt, snap_rden);
        check("cal_loss_nocmd",  addr_log.size(), snap_beats);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
